// File: rtl/bram_sdp_fifo.sv
// Synchronous FIFO on an inferred simple-dual-port block RAM.
// The read data has one cycle of latency. All flags are registered and are
// recomputed from the next-state pointers and count on the same edge, so no
// output depends combinationally on an input.
module bram_sdp_fifo #(
  parameter int DATA_WIDTH   = 18,
  parameter int DEPTH        = 1024,
  parameter int AFULL_LEVEL  = DEPTH - 4,
  parameter int AEMPTY_LEVEL = 4,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  CLK_i,
  input  logic                  RST_ni,
  input  logic                  FLUSH_i,
  input  logic                  WR_EN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  output logic                  FULL_o,
  output logic                  ALMOST_FULL_o,
  input  logic                  RD_EN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  output logic                  EMPTY_o,
  output logic                  ALMOST_EMPTY_o,
  output logic [AW:0]           COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o
);

  // Reject parameter sets that cannot map onto the SDP array.
  if (DATA_WIDTH < 1 || DATA_WIDTH > 36) begin : g_bad_width
    $error("bram_sdp_fifo: DATA_WIDTH must be in 1..36");
  end
  if (DEPTH < 4 || DEPTH > 32768 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bram_sdp_fifo: DEPTH must be a power of two in 4..32768");
  end

  // The almost-full flag is derived from the count, so an empty FIFO shows it
  // only when the threshold is zero.
  localparam logic AFULL_RST = (0 >= AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]           wptr_q, rptr_q, count_q;
  logic [AW:0]           wptr_d, rptr_d, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  full_d, empty_d, afull_d, aempty_d;
  logic                  ovf_q, udf_q, ovf_d, udf_d;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_acc, rd_acc;

  // Accepts use the registered flags only; flush drops both requests.
  assign wr_acc = WR_EN_i & ~full_q  & ~FLUSH_i;
  assign rd_acc = RD_EN_i & ~empty_q & ~FLUSH_i;

  // Next-state pointers, count, flags and sticky errors.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (WR_EN_i & full_q);
    udf_d   = udf_q | (RD_EN_i & empty_q);

    if (FLUSH_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + (AW+1)'(1);
      if (rd_acc) rptr_d = rptr_q + (AW+1)'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    full_d   = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (int'(count_d) >= AFULL_LEVEL);
    aempty_d = (int'(count_d) <= AEMPTY_LEVEL);
  end

  // Control state register.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AFULL_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= rd_acc;
    end
  end

  // Memory write port.
  always_ff @(posedge CLK_i) begin
    // NOTE: the array has no reset; a reset term would stop it from mapping
    // onto block RAM. Stale contents are never visible through the pointers.
    if (wr_acc) mem[wptr_q[AW-1:0]] <= WDATA_i;
  end

  // Memory read port with output register; holds when no read is accepted.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      rdata_q <= '0;
    end else if (FLUSH_i) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem[rptr_q[AW-1:0]];
    end
  end

  assign FULL_o         = full_q;
  assign ALMOST_FULL_o  = afull_q;
  assign EMPTY_o        = empty_q;
  assign ALMOST_EMPTY_o = aempty_q;
  assign COUNT_o        = count_q;
  assign OVERFLOW_o     = ovf_q;
  assign UNDERFLOW_o    = udf_q;
  assign RVALID_o       = rvalid_q;
  assign RDATA_o        = rdata_q;

endmodule

// File: tb/tb_bram_sdp_fifo.sv
// Directed bench for bram_sdp_fifo (DATA_WIDTH=9, DEPTH=16, AFULL=12, AEMPTY=2).
module tb_bram_sdp_fifo;

  localparam int DW = 9;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wr_en, rd_en;
  logic [DW-1:0] wdata;
  logic          full, afull, empty, aempty, rvalid, ovf, udf;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          fl;
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    int            count;
    logic          empty;
    logic          full;
    logic          afull;
    logic          aempty;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t vecs[$];

  bram_sdp_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (12),
    .AEMPTY_LEVEL(2)
  ) dut (
    .CLK_i         (clk),
    .RST_ni        (rst_n),
    .FLUSH_i       (flush),
    .WR_EN_i       (wr_en),
    .WDATA_i       (wdata),
    .FULL_o        (full),
    .ALMOST_FULL_o (afull),
    .RD_EN_i       (rd_en),
    .RDATA_o       (rdata),
    .RVALID_o      (rvalid),
    .EMPTY_o       (empty),
    .ALMOST_EMPTY_o(aempty),
    .COUNT_o       (count),
    .OVERFLOW_o    (ovf),
    .UNDERFLOW_o   (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, return just after the next rising edge.
  task automatic apply(input logic fl, input logic wr, input logic [DW-1:0] wd,
                       input logic rd);
    @(negedge clk);
    flush = fl;
    wr_en = wr;
    wdata = wd;
    rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic wr, input logic [DW-1:0] wd,
                     input logic rd, input int cnt, input logic emp, input logic ful,
                     input logic af, input logic ae, input logic rv,
                     input logic [DW-1:0] rdat, input logic ov, input logic un);
    vec_t v;
    v.fl = fl; v.wr = wr; v.wd = wd; v.rd = rd;
    v.count = cnt; v.empty = emp; v.full = ful; v.afull = af; v.aempty = ae;
    v.rvalid = rv; v.rdata = rdat; v.ovf = ov; v.udf = un;
    vecs.push_back(v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},  0, 32'(count),  0);
    check({tag, "_empty"},  0, 32'(empty),  1);
    check({tag, "_aempty"}, 0, 32'(aempty), 1);
    check({tag, "_full"},   0, 32'(full),   0);
    check({tag, "_afull"},  0, 32'(afull),  0);
    check({tag, "_rvalid"}, 0, 32'(rvalid), 0);
    check({tag, "_rdata"},  0, 32'(rdata),  0);
    check({tag, "_ovf"},    0, 32'(ovf),    0);
    check({tag, "_udf"},    0, 32'(udf),    0);
  endtask

  initial begin
    logic          wr, rd;
    logic [DW-1:0] wd, exp_word;
    logic [DW-1:0] model_q[$];
    int            cnt, wrote, readn, cyc;

    rst_n = 1'b0;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;

    // Scenario 1: three writes, three back-to-back reads.
    //   fl wr wd      rd  cnt emp ful af ae rv rdata   ov un
    add(0, 1, 9'h1A5, 0,  1,  0,  0,  0, 1, 0, 9'h000, 0, 0);
    add(0, 1, 9'h0FF, 0,  2,  0,  0,  0, 1, 0, 9'h000, 0, 0);
    add(0, 1, 9'h100, 0,  3,  0,  0,  0, 0, 0, 9'h000, 0, 0);
    add(0, 0, 9'h000, 1,  2,  0,  0,  0, 1, 1, 9'h1A5, 0, 0);
    add(0, 0, 9'h000, 1,  1,  0,  0,  0, 1, 1, 9'h0FF, 0, 0);
    add(0, 0, 9'h000, 1,  0,  1,  0,  0, 1, 1, 9'h100, 0, 0);
    add(0, 0, 9'h000, 0,  0,  1,  0,  0, 1, 0, 9'h100, 0, 0);
    // Scenario 2: fill to 16, then a dropped 17th write.
    for (int i = 0; i < 16; i++)
      add(0, 1, 9'(9'h080 + i), 0, i + 1, 0, (i + 1 == 16), (i + 1 >= 12),
          (i + 1 <= 2), 0, 9'h100, 0, 0);
    add(0, 1, 9'h1FF, 0, 16, 0, 1, 1, 0, 0, 9'h100, 1, 0);
    // Scenario 3: write+read while full, then both again, then one read.
    add(0, 1, 9'h1EE, 1, 15, 0, 0, 1, 0, 1, 9'h080, 1, 0);
    add(0, 1, 9'h1EE, 1, 15, 0, 0, 1, 0, 1, 9'h081, 1, 0);
    add(0, 0, 9'h000, 1, 14, 0, 0, 1, 0, 1, 9'h082, 1, 0);
    // Flush returns everything to reset values.
    add(1, 0, 9'h000, 0,  0, 1, 0, 0, 1, 0, 9'h000, 0, 0);
    // Scenario 5: underflow first so the flush has a sticky flag to clear.
    add(0, 0, 9'h000, 1,  0, 1, 0, 0, 1, 0, 9'h000, 0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 1, 9'(9'h011 + i), 0, i + 1, 0, 0, 0, (i + 1 <= 2), 0, 9'h000, 0, 1);
    add(1, 1, 9'h1FF, 1,  0, 1, 0, 0, 1, 0, 9'h000, 0, 0);
    add(0, 0, 9'h000, 1,  0, 1, 0, 0, 1, 0, 9'h000, 0, 1);
    add(1, 0, 9'h000, 0,  0, 1, 0, 0, 1, 0, 9'h000, 0, 0);

    // Reset state, observed while reset is still asserted.
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].fl, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      check("count",  i, 32'(count),  32'(vecs[i].count));
      check("empty",  i, 32'(empty),  32'(vecs[i].empty));
      check("full",   i, 32'(full),   32'(vecs[i].full));
      check("afull",  i, 32'(afull),  32'(vecs[i].afull));
      check("aempty", i, 32'(aempty), 32'(vecs[i].aempty));
      check("rvalid", i, 32'(rvalid), 32'(vecs[i].rvalid));
      check("rdata",  i, 32'(rdata),  32'(vecs[i].rdata));
      check("ovf",    i, 32'(ovf),    32'(vecs[i].ovf));
      check("udf",    i, 32'(udf),    32'(vecs[i].udf));
    end

    // Scenario 4: 40 words through a 16-deep FIFO with occupancy kept in 0..5.
    cnt = 0; wrote = 0; readn = 0; cyc = 0;
    while (readn < 40 && cyc < 400) begin
      wr = (wrote < 40) && (cnt < 5) && (cyc % 3 != 2);
      rd = (cnt > 0) && ((cyc % 2 == 1) || (cnt == 5));
      wd = 9'(wrote * 37 + 5);
      apply(0, wr, wd, rd);
      if (rd) begin
        exp_word = model_q.pop_front();
        readn++;
        check("wrap_rvalid", cyc, 32'(rvalid), 1);
        check("wrap_rdata",  cyc, 32'(rdata),  32'(exp_word));
      end else begin
        check("wrap_rvalid", cyc, 32'(rvalid), 0);
      end
      if (wr) begin
        model_q.push_back(wd);
        wrote++;
      end
      cnt = cnt + int'(wr) - int'(rd);
      check("wrap_count",  cyc, 32'(count),  32'(cnt));
      check("wrap_aempty", cyc, 32'(aempty), 32'(cnt <= 2));
      check("wrap_empty",  cyc, 32'(empty),  32'(cnt == 0));
      check("wrap_udf",    cyc, 32'(udf),    0);
      cyc++;
    end
    check("wrap_reads", 0, 32'(readn), 40);

    // Scenario 6: asynchronous reset mid-stream with COUNT_o = 7.
    for (int i = 0; i < 8; i++) apply(0, 1, 9'(9'h0A0 + i), 0);
    apply(0, 0, 9'h000, 1);
    check("pre_rst_count",  0, 32'(count),  7);
    check("pre_rst_rvalid", 0, 32'(rvalid), 1);
    check("pre_rst_rdata",  0, 32'(rdata),  32'(9'h0A0));
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 1, 9'h055, 0);
    check("post_rst_count", 0, 32'(count), 1);
    apply(0, 0, 9'h000, 1);
    check("post_rst_rvalid", 0, 32'(rvalid), 1);
    check("post_rst_rdata",  0, 32'(rdata),  32'(9'h055));
    check("post_rst_empty",  0, 32'(empty),  1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
